pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage core. It decodes the F/D and D/X instruction fields and detects load-use hazards, inserting one stall and bubble. It flushes F/D and D/X on a taken branch or jump, and runs the launch/wait handshake with the shared mult/div unit, freezing the front of the pipe until the result is ready. It also keeps a saturating stall-cycle counter and a sticky mult/div timeout flag.

---
 rtl/pipe_hazard_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//
// Purpose: sequencing control for the 5-stage core. It handles three things:
//   - It detects load-use hazards between the D/X load and the F/D
//     instruction, and answers with one stall plus one bubble.
//   - It flushes F/D and D/X when a branch or jump is taken in X.
//   - It runs the launch/wait handshake with the shared mult/div unit. The
//     front of the pipe is frozen until the result is ready or the wait
//     times out.
// It also keeps a saturating stall-cycle counter and a sticky timeout flag.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   fd_opcode/rs/rt/rd  F/D instruction fields
//   dx_opcode/aluop/rd  D/X instruction fields
//   branch_taken        taken branch/jump resolved in X this cycle
//   md_ready            mult/div result valid (single-cycle pulse)
//   stall, bubble_dx    load-use response: hold PC and F/D, NOP into D/X
//   flush               NOP into F/D and D/X at the next edge
//   md_stall            hold PC, F/D and D/X, NOP into X/M
//   md_ctrl_mult/div    one-cycle launch pulses to the mult/div unit
//   md_timeout          sticky: a mult/div wait ran out of time
//   stall_cycles        saturating count of cycles with stall|md_stall
module pipe_hazard_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       fd_opcode,
  input  logic [4:0]       fd_rs,
  input  logic [4:0]       fd_rt,
  input  logic [4:0]       fd_rd,
  input  logic [4:0]       dx_opcode,
  input  logic [4:0]       dx_aluop,
  input  logic [4:0]       dx_rd,
  input  logic             branch_taken,
  input  logic             md_ready,
  output logic             stall,
  output logic             bubble_dx,
  output logic             flush,
  output logic             md_stall,
  output logic             md_ctrl_mult,
  output logic             md_ctrl_div,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_BEQ  = 5'b01001;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  localparam logic [4:0] ALU_MULT = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  localparam int            TW       = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [TW-1:0] CNT_LAST = TW'(MD_TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             en);
    if (en && (v != {CNT_W{1'b1}})) return v + 1'b1;
    return v;
  endfunction

  state_t            state_q, state_d;
  logic [TW-1:0]     wcnt_q, wcnt_d;
  logic              md_timeout_q, md_timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic              rst_q;

  logic use_rs, use_rt, use_rd, use_r30;
  logic src_hit, load_use;
  logic dx_mult, dx_div, md_block;
  logic md_stall_c, mult_c, div_c;

  // F/D source-register usage by opcode
  always_comb begin
    use_rs  = 1'b0;
    use_rt  = 1'b0;
    use_rd  = 1'b0;
    use_r30 = 1'b0;
    case (fd_opcode)
      OP_R:                          begin use_rs = 1'b1; use_rt = 1'b1; end
      OP_ADDI, OP_LW:                use_rs = 1'b1;
      OP_SW, OP_BNE, OP_BLT, OP_BEQ: begin use_rd = 1'b1; use_rs = 1'b1; end
      OP_JR:                         use_rd = 1'b1;
      OP_BEX:                        use_r30 = 1'b1;
      default:                       ;
    endcase
  end

  assign src_hit  = (use_rs  && (fd_rs == dx_rd)) ||
                    (use_rt  && (fd_rt == dx_rd)) ||
                    (use_rd  && (fd_rd == dx_rd)) ||
                    (use_r30 && (dx_rd == 5'd30));
  assign load_use = (dx_opcode == OP_LW) && (dx_rd != 5'd0) && src_hit;

  assign dx_mult  = (dx_opcode == OP_R) && (dx_aluop == ALU_MULT);
  assign dx_div   = (dx_opcode == OP_R) && (dx_aluop == ALU_DIV);

  // Mult/div activity is suppressed while reset is held and in the first
  // cycle after it, so a mult/div left sitting in D/X cannot fire a pulse
  // until the pipe has had one clean cycle.
  assign md_block = reset | rst_q;

  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    md_timeout_d = md_timeout_q;
    md_stall_c   = 1'b0;
    mult_c       = 1'b0;
    div_c        = 1'b0;
    if (!md_block) begin
      case (state_q)
        S_IDLE: begin
          if (dx_mult || dx_div) begin
            md_stall_c = 1'b1;
            mult_c     = dx_mult;
            div_c      = dx_div;
            wcnt_d     = '0;
            state_d    = S_BUSY;
          end
        end
        S_BUSY: begin
          // The result cycle and the timeout cycle both release the pipe
          // immediately; neither relaunches.
          if (md_ready) begin
            state_d = S_IDLE;
          end else if (wcnt_q == CNT_LAST) begin
            md_timeout_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            md_stall_c = 1'b1;
            wcnt_d     = wcnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A mult/div freeze ignores branches; a flush overrides the load-use stall.
  assign md_stall     = md_stall_c;
  assign md_ctrl_mult = mult_c;
  assign md_ctrl_div  = div_c;
  assign flush        = branch_taken & ~md_stall_c;
  assign stall        = load_use & ~flush & ~md_stall_c;
  assign bubble_dx    = load_use & ~flush & ~md_stall_c;
  assign md_timeout   = md_timeout_q;
  assign stall_cycles = stall_cnt_q;

  always_ff @(posedge clock) begin
    rst_q <= reset;
    if (reset) begin
      state_q      <= S_IDLE;
      wcnt_q       <= '0;
      md_timeout_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      md_timeout_q <= md_timeout_d;
      stall_cnt_q  <= sat_inc(stall_cnt_q, stall | md_stall_c);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl. Two instances run on shared inputs:
//   u_a: MD_TIMEOUT=64, CNT_W=16
//   u_b: MD_TIMEOUT=8,  CNT_W=4 (so the stall counter saturates)
// A behavioural model built from the hazard/flush/handshake rules predicts
// every output each cycle. Directed steps are followed by random stimulus.
module tb_pipe_hazard_ctrl;

  localparam logic [4:0] R = 5'd0, J = 5'd1, BNE = 5'd2, JAL = 5'd3, JR = 5'd4,
                         ADDI = 5'd5, BLT = 5'd6, SW = 5'd7, LW = 5'd8,
                         BEQ = 5'd9, SETX = 5'd21, BEX = 5'd22;
  localparam logic [4:0] MULT = 5'd6, DIV = 5'd7;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [4:0] fd_opcode = '0, fd_rs = '0, fd_rt = '0, fd_rd = '0;
  logic [4:0] dx_opcode = '0, dx_aluop = '0, dx_rd = '0;
  logic branch_taken = 1'b0, md_ready = 1'b0;

  logic a_stall, a_bubble, a_flush, a_mds, a_mul, a_div, a_to;
  logic b_stall, b_bubble, b_flush, b_mds, b_mul, b_div, b_to;
  logic [15:0] a_sc;
  logic [3:0]  b_sc;

  always #5 clock = ~clock;

  pipe_hazard_ctrl #(.MD_TIMEOUT(64), .CNT_W(16)) u_a (
    .clock(clock), .reset(reset), .fd_opcode(fd_opcode), .fd_rs(fd_rs),
    .fd_rt(fd_rt), .fd_rd(fd_rd), .dx_opcode(dx_opcode), .dx_aluop(dx_aluop),
    .dx_rd(dx_rd), .branch_taken(branch_taken), .md_ready(md_ready),
    .stall(a_stall), .bubble_dx(a_bubble), .flush(a_flush), .md_stall(a_mds),
    .md_ctrl_mult(a_mul), .md_ctrl_div(a_div), .md_timeout(a_to),
    .stall_cycles(a_sc));

  pipe_hazard_ctrl #(.MD_TIMEOUT(8), .CNT_W(4)) u_b (
    .clock(clock), .reset(reset), .fd_opcode(fd_opcode), .fd_rs(fd_rs),
    .fd_rt(fd_rt), .fd_rd(fd_rd), .dx_opcode(dx_opcode), .dx_aluop(dx_aluop),
    .dx_rd(dx_rd), .branch_taken(branch_taken), .md_ready(md_ready),
    .stall(b_stall), .bubble_dx(b_bubble), .flush(b_flush), .md_stall(b_mds),
    .md_ctrl_mult(b_mul), .md_ctrl_div(b_div), .md_timeout(b_to),
    .stall_cycles(b_sc));

  int checks = 0;
  int errors = 0;

  // model state
  int TO[2]   = '{64, 8};
  int SMAX[2] = '{65535, 15};
  bit m_busy[2];
  int m_wait[2];
  bit m_to[2];
  int m_sc[2];
  bit m_rstp;
  bit e_stall[2], e_flush[2], e_mds[2], e_mul[2], e_div[2];

  int n_mds_a, n_mds_b, n_mul_a, n_div_a, n_div_b;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] src_mask(input logic [4:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd);
    logic [31:0] one = 32'd1;
    case (op)
      R:                  return (one << rs) | (one << rt);
      ADDI, LW:           return one << rs;
      SW, BNE, BLT, BEQ:  return (one << rd) | (one << rs);
      JR:                 return one << rd;
      BEX:                return one << 30;
      default:            return 32'd0;
    endcase
  endfunction

  task automatic predict();
    logic [31:0] msk;
    bit lu, blk, is_mul, is_div;
    msk    = src_mask(fd_opcode, fd_rs, fd_rt, fd_rd);
    lu     = (dx_opcode == LW) && (dx_rd != 0) && msk[dx_rd];
    blk    = reset || m_rstp;
    is_mul = (dx_opcode == R) && (dx_aluop == MULT);
    is_div = (dx_opcode == R) && (dx_aluop == DIV);
    for (int i = 0; i < 2; i++) begin
      e_mul[i] = !blk && !m_busy[i] && is_mul;
      e_div[i] = !blk && !m_busy[i] && is_div;
      if (blk)             e_mds[i] = 1'b0;
      else if (!m_busy[i]) e_mds[i] = is_mul || is_div;
      else                 e_mds[i] = !md_ready && (m_wait[i] < TO[i] - 1);
      e_flush[i] = branch_taken && !e_mds[i];
      e_stall[i] = lu && !e_flush[i] && !e_mds[i];
    end
  endtask

  task automatic advance();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_busy[i] = 0; m_wait[i] = 0; m_to[i] = 0; m_sc[i] = 0;
      end else begin
        if ((e_stall[i] || e_mds[i]) && m_sc[i] < SMAX[i]) m_sc[i]++;
        if (!m_busy[i]) begin
          if (e_mul[i] || e_div[i]) begin m_busy[i] = 1; m_wait[i] = 0; end
        end else if (md_ready) begin
          m_busy[i] = 0;
        end else if (m_wait[i] == TO[i] - 1) begin
          m_busy[i] = 0; m_to[i] = 1;
        end else begin
          m_wait[i]++;
        end
      end
    end
    m_rstp = reset;
  endtask

  // One clock cycle: check all outputs against the model, then take the edge.
  task automatic cyc();
    #1;
    predict();
    chk("stall64",  32'(a_stall),  32'(e_stall[0]));
    chk("bubble64", 32'(a_bubble), 32'(e_stall[0]));
    chk("flush64",  32'(a_flush),  32'(e_flush[0]));
    chk("mdstl64",  32'(a_mds),    32'(e_mds[0]));
    chk("mult64",   32'(a_mul),    32'(e_mul[0]));
    chk("div64",    32'(a_div),    32'(e_div[0]));
    chk("tmo64",    32'(a_to),     32'(m_to[0]));
    chk("scnt64",   32'(a_sc),     32'(m_sc[0]));
    chk("stall8",   32'(b_stall),  32'(e_stall[1]));
    chk("bubble8",  32'(b_bubble), 32'(e_stall[1]));
    chk("flush8",   32'(b_flush),  32'(e_flush[1]));
    chk("mdstl8",   32'(b_mds),    32'(e_mds[1]));
    chk("mult8",    32'(b_mul),    32'(e_mul[1]));
    chk("div8",     32'(b_div),    32'(e_div[1]));
    chk("tmo8",     32'(b_to),     32'(m_to[1]));
    chk("scnt8",    32'(b_sc),     32'(m_sc[1]));
    n_mds_a += int'(a_mds); n_mds_b += int'(b_mds);
    n_mul_a += int'(a_mul); n_div_a += int'(a_div); n_div_b += int'(b_div);
    @(posedge clock);
    advance();
    #1;
  endtask

  task automatic drv(input logic [4:0] fop, input logic [4:0] frs, input logic [4:0] frt,
                     input logic [4:0] frd, input logic [4:0] dop, input logic [4:0] dalu,
                     input logic [4:0] drd, input logic bt, input logic rdy);
    fd_opcode = fop; fd_rs = frs; fd_rt = frt; fd_rd = frd;
    dx_opcode = dop; dx_aluop = dalu; dx_rd = drd;
    branch_taken = bt; md_ready = rdy;
    #1;
  endtask

  task automatic clr_counts();
    n_mds_a = 0; n_mds_b = 0; n_mul_a = 0; n_div_a = 0; n_div_b = 0;
  endtask

  initial begin
    int r;
    clr_counts();
    // initial reset, model starts from the reset state
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_wait[i] = 0; m_to[i] = 0; m_sc[i] = 0;
    end
    m_rstp = 1'b1;
    cyc();
    reset = 1'b0;

    // first cycle after reset: a mult in D/X must not launch
    drv(J, 0, 0, 0, R, MULT, 0, 0, 0);
    chk("post_rst_mds",  32'(a_mds), 0);
    chk("post_rst_mult", 32'(a_mul), 0);
    chk("post_rst_sc",   32'(a_sc),  0);
    chk("post_rst_tmo",  32'(a_to),  0);
    cyc();

    // load-use: lw r5 then addi using r5
    drv(ADDI, 5, 0, 0, LW, 0, 5, 0, 0);
    chk("lu_stall",  32'(a_stall),  1);
    chk("lu_bubble", 32'(a_bubble), 1);
    cyc();
    drv(ADDI, 5, 0, 0, R, 0, 0, 0, 0);
    chk("lu_once", 32'(a_stall), 0);
    chk("lu_cnt",  32'(a_sc),    1);
    cyc();
    drv(ADDI, 0, 0, 0, LW, 0, 0, 0, 0);
    chk("lu_r0", 32'(a_stall), 0);
    cyc();
    drv(BEX, 0, 0, 0, LW, 0, 30, 0, 0);
    chk("lu_bex", 32'(a_stall), 1);
    cyc();
    drv(J, 7, 7, 7, LW, 0, 7, 0, 0);
    chk("lu_j", 32'(a_stall), 0);
    cyc();
    drv(SW, 0, 0, 3, LW, 0, 3, 0, 0);
    chk("lu_sw", 32'(a_stall), 1);
    cyc();
    // flush beats load-use
    drv(SW, 0, 0, 3, LW, 0, 3, 1, 0);
    chk("fl_flush",  32'(a_flush),  1);
    chk("fl_stall",  32'(a_stall),  0);
    chk("fl_bubble", 32'(a_bubble), 0);
    cyc();
    chk("fl_cnt", 32'(a_sc), 3);

    // mult, md_ready on the 17th cycle after launch
    clr_counts();
    drv(J, 0, 0, 0, R, MULT, 4, 0, 0);
    chk("mul_pulse", 32'(a_mul), 1);
    chk("mul_mds",   32'(a_mds), 1);
    cyc();
    for (int k = 1; k <= 16; k++) begin
      drv(J, 0, 0, 0, R, MULT, 4, (k == 5), 0);
      if (k == 5) chk("busy_noflush", 32'(a_flush), 0);
      cyc();
    end
    drv(J, 0, 0, 0, R, MULT, 4, 0, 1);
    chk("mul_rdy_mds",   32'(a_mds), 0);
    chk("mul_rdy_pulse", 32'(a_mul), 0);
    cyc();
    drv(J, 0, 0, 0, R, 0, 0, 0, 0);
    cyc();
    chk("mul_mds_cnt",   n_mds_a, 17);
    chk("mul_pulse_cnt", n_mul_a, 1);

    // back-to-back div
    reset = 1'b1;
    drv(J, 0, 0, 0, R, 0, 0, 0, 0);
    cyc();
    reset = 1'b0;
    cyc();
    clr_counts();
    drv(J, 0, 0, 0, R, DIV, 2, 0, 0);
    chk("div1_pulse", 32'(a_div), 1);
    cyc();
    for (int k = 1; k <= 3; k++) cyc();
    drv(J, 0, 0, 0, R, DIV, 2, 0, 1);
    chk("div1_rdy", 32'(a_mds), 0);
    chk("div1_nore", 32'(a_div), 0);
    cyc();
    drv(J, 0, 0, 0, R, DIV, 3, 0, 0);
    chk("div2_pulse", 32'(a_div), 1);
    chk("div2_mds",   32'(a_mds), 1);
    cyc();
    for (int k = 1; k <= 2; k++) cyc();
    drv(J, 0, 0, 0, R, DIV, 3, 0, 1);
    cyc();
    drv(J, 0, 0, 0, R, 0, 0, 0, 0);
    cyc();
    chk("div_cnt64", n_div_a, 2);
    chk("div_cnt8",  n_div_b, 2);

    // timeout on the MD_TIMEOUT=8 instance
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    chk("tmo_clear", 32'(b_to), 0);
    clr_counts();
    drv(J, 0, 0, 0, R, MULT, 1, 0, 0);
    for (int k = 0; k <= 7; k++) cyc();
    chk("tmo_release", 32'(b_mds), 0);
    chk("tmo_notyet",  32'(b_to),  0);
    cyc();
    drv(J, 0, 0, 0, R, 0, 0, 0, 0);
    chk("tmo_set",     32'(b_to),   1);
    chk("tmo_mds_cnt", n_mds_b,     8);
    cyc();
    drv(J, 0, 0, 0, R, MULT, 1, 0, 0);
    cyc(); cyc();
    chk("tmo_sticky", 32'(b_to), 1);
    // reset mid-BUSY, mult still in D/X
    reset = 1'b1;
    #1;
    chk("rst_mds",   32'(a_mds), 0);
    chk("rst_pulse", 32'(a_mul), 0);
    cyc();
    reset = 1'b0;
    #1;
    chk("rst_after_mds",  32'(a_mds), 0);
    chk("rst_after_mul",  32'(a_mul), 0);
    chk("rst_after_sc64", 32'(a_sc),  0);
    chk("rst_after_sc8",  32'(b_sc),  0);
    chk("rst_after_tmo",  32'(b_to),  0);
    cyc();
    drv(J, 0, 0, 0, R, 0, 0, 0, 0);
    cyc();

    // random stimulus against the model
    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 9);
      if (r < 3)      dx_opcode = LW;
      else if (r < 6) dx_opcode = R;
      else            dx_opcode = 5'($urandom_range(0, 31));
      dx_aluop = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(6, 7))
                                             : 5'($urandom_range(0, 31));
      dx_rd = ($urandom_range(0, 7) == 0) ? 5'd30 : 5'($urandom_range(0, 3));
      r = $urandom_range(0, 13);
      case (r)
        0: fd_opcode = R;   1: fd_opcode = J;    2: fd_opcode = BNE;
        3: fd_opcode = JAL; 4: fd_opcode = JR;   5: fd_opcode = ADDI;
        6: fd_opcode = BLT; 7: fd_opcode = SW;   8: fd_opcode = LW;
        9: fd_opcode = BEQ; 10: fd_opcode = SETX; 11: fd_opcode = BEX;
        default: fd_opcode = 5'($urandom_range(0, 31));
      endcase
      fd_rs = 5'($urandom_range(0, 3));
      fd_rt = 5'($urandom_range(0, 3));
      fd_rd = 5'($urandom_range(0, 3));
      branch_taken = ($urandom_range(0, 3) == 0);
      md_ready     = ($urandom_range(0, 11) == 0);
      reset        = ($urandom_range(0, 149) == 0);
      cyc();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
